// File: rtl/llfifo_rr_scheduler.sv
// Push/pop sequencer for a shared linked-list FIFO serving NUM_FIFOS queues:
// round-robin push grants under a per-queue quota, round-robin pops into one registered output.
module llfifo_rr_scheduler #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned NUM_FIFOS = 2,
  parameter int unsigned QUOTA     = 2,
  parameter int unsigned SEL_WIDTH = $clog2(NUM_FIFOS),
  parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_FIFOS-1:0]           in_valid,
  input  logic [NUM_FIFOS*WIDTH-1:0]     in_data,
  output logic [NUM_FIFOS-1:0]           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [SEL_WIDTH-1:0]           out_qid,
  output logic                           ff_push,
  output logic [SEL_WIDTH-1:0]           ff_push_sel,
  output logic [WIDTH-1:0]               ff_data_in,
  output logic                           ff_pop,
  output logic [SEL_WIDTH-1:0]           ff_pop_sel,
  input  logic                           ff_full,
  input  logic [NUM_FIFOS-1:0]           ff_empty,
  input  logic [WIDTH-1:0]               ff_data_out,
  output logic                           cnt_err
);

  logic [SEL_WIDTH-1:0] push_rr_q, push_rr_d;
  logic [SEL_WIDTH-1:0] pop_rr_q, pop_rr_d;
  logic [CNT_WIDTH-1:0] count_q [NUM_FIFOS];
  logic [CNT_WIDTH-1:0] count_d [NUM_FIFOS];
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0] out_qid_q, out_qid_d;
  logic                 cnt_err_q, cnt_err_d;

  logic [WIDTH-1:0]     in_word [NUM_FIFOS];
  logic                 grant_found, push_go;
  logic [SEL_WIDTH-1:0] grant_sel, push_scan;
  logic                 cand_found, pop_go, load_en;
  logic [SEL_WIDTH-1:0] cand_sel, pop_scan;
  logic                 mismatch;

  function automatic logic [SEL_WIDTH-1:0] wrap_inc(input logic [SEL_WIDTH-1:0] s);
    return (32'(s) == NUM_FIFOS - 1) ? '0 : s + 1'b1;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      in_word[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Scan walks the ring from the pointer; the first hit wins.
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = push_rr_q;
    push_scan   = push_rr_q;
    for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
      if (!grant_found && in_valid[push_scan] && !ff_full &&
          (count_q[push_scan] < CNT_WIDTH'(QUOTA))) begin
        grant_found = 1'b1;
        grant_sel   = push_scan;
      end
      push_scan = wrap_inc(push_scan);
    end
  end

  always_comb begin
    cand_found = 1'b0;
    cand_sel   = pop_rr_q;
    pop_scan   = pop_rr_q;
    for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
      if (!cand_found && !ff_empty[pop_scan] && (count_q[pop_scan] != '0)) begin
        cand_found = 1'b1;
        cand_sel   = pop_scan;
      end
      pop_scan = wrap_inc(pop_scan);
    end
  end

  assign push_go     = rst && grant_found;
  assign load_en     = !out_valid_q || out_ready;
  assign pop_go      = rst && load_en && cand_found;

  assign in_ready    = push_go ? (NUM_FIFOS'(1) << grant_sel) : '0;
  assign ff_push     = push_go;
  assign ff_push_sel = grant_sel;
  assign ff_data_in  = in_word[grant_sel];
  assign ff_pop      = pop_go;
  assign ff_pop_sel  = pop_go ? cand_sel : pop_rr_q;

  always_comb begin
    push_rr_d   = push_go ? wrap_inc(grant_sel) : push_rr_q;
    pop_rr_d    = pop_go ? wrap_inc(cand_sel) : pop_rr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_qid_d   = out_qid_q;
    if (load_en) begin
      out_valid_d = pop_go;
      if (pop_go) begin
        out_data_d = ff_data_out;
        out_qid_d  = cand_sel;
      end
    end
    mismatch = 1'b0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      count_d[i] = count_q[i]
                 + CNT_WIDTH'(push_go && (grant_sel == SEL_WIDTH'(i)))
                 - CNT_WIDTH'(pop_go && (cand_sel == SEL_WIDTH'(i)));
      mismatch   = mismatch | ((count_q[i] == '0) != ff_empty[i]);
    end
    cnt_err_d = cnt_err_q | mismatch;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      push_rr_q   <= '0;
      pop_rr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_qid_q   <= '0;
      cnt_err_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      push_rr_q   <= push_rr_d;
      pop_rr_q    <= pop_rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_qid_q   <= out_qid_d;
      cnt_err_q   <= cnt_err_d;
      for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_qid   = out_qid_q;
  assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_llfifo_rr_scheduler.sv
// Directed bench for llfifo_rr_scheduler with a behavioural shared-FIFO model
// and per-queue scoreboards checked whenever the output stream transfers.
module tb_llfifo_rr_scheduler;
  localparam int unsigned W  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned N  = 2;
  localparam int unsigned Q  = 2;
  localparam int unsigned SW = 1;

  localparam logic [1:0] EXP2 [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
  localparam logic [1:0] EXP3 [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
  localparam logic [1:0] EXP5 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  localparam int         QID2 [5] = '{0, 1, 0, 1, 0};
  localparam int         QID5 [4] = '{0, 1, 0, 1};

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_qid;
  logic          ff_push, ff_pop, ff_full, cnt_err;
  logic [SW-1:0] ff_push_sel, ff_pop_sel;
  logic [W-1:0]  ff_data_in, ff_data_out;
  logic [N-1:0]  ff_empty;

  llfifo_rr_scheduler #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(N), .QUOTA(Q)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_qid(out_qid),
    .ff_push(ff_push), .ff_push_sel(ff_push_sel), .ff_data_in(ff_data_in),
    .ff_pop(ff_pop), .ff_pop_sel(ff_pop_sel),
    .ff_full(ff_full), .ff_empty(ff_empty), .ff_data_out(ff_data_out),
    .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  // Shared FIFO model: per-queue rings, total occupancy bounded by D.
  logic [W-1:0] mem [N][D];
  int unsigned  rdp [N];
  int unsigned  wrp [N];
  int unsigned  mcnt [N];
  int unsigned  mtot;

  always_comb begin
    mtot     = 0;
    ff_empty = '0;
    for (int i = 0; i < N; i++) begin
      mtot        += mcnt[i];
      ff_empty[i]  = (mcnt[i] == 0);
    end
    ff_full     = (mtot >= D);
    ff_data_out = mem[ff_pop_sel][rdp[ff_pop_sel]];
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        rdp[i] <= 0; wrp[i] <= 0; mcnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++)
        mcnt[i] <= mcnt[i] + ((ff_push && ff_push_sel == i) ? 1 : 0)
                           - ((ff_pop && ff_pop_sel == i) ? 1 : 0);
      if (ff_push) begin
        mem[ff_push_sel][wrp[ff_push_sel]] <= ff_data_in;
        wrp[ff_push_sel] <= (wrp[ff_push_sel] + 1) % D;
      end
      if (ff_pop) rdp[ff_pop_sel] <= (rdp[ff_pop_sel] + 1) % D;
    end
  end

  logic [W-1:0] sbq [N][$];
  int           qid_log [$];
  logic [W-1:0] nxt [N];
  int           rem [N];
  int           total = 0;
  int           bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i]         = (rem[i] != 0);
      in_data[i*W +: W]   = nxt[i];
    end
  endtask

  // Monitor at the falling edge, then advance to just after the next rising edge.
  task automatic cyc();
    @(negedge clk);
    if (rst) begin
      chk("push_vs_full", 32'(ff_push & ff_full), 0);
      chk("pop_vs_empty", 32'(ff_pop & ff_empty[ff_pop_sel]), 0);
      chk("ready_onehot0", 32'($onehot0(in_ready)), 1);
      chk("cnt_err_low", 32'(cnt_err), 0);
      if (out_valid && out_ready) begin
        qid_log.push_back(int'(out_qid));
        chk("sb_has_entry", 32'(sbq[out_qid].size() != 0), 1);
        if (sbq[out_qid].size() != 0) chk("sb_data", 32'(out_data), 32'(sbq[out_qid].pop_front()));
      end
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          sbq[i].push_back(in_data[i*W +: W]);
          nxt[i]++;
          rem[i]--;
        end
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (k < 30 && (out_valid || sbq[0].size() != 0 || sbq[1].size() != 0)) begin
      cyc();
      k++;
    end
    chk({tag, "_idle"}, 32'(out_valid), 0);
    chk({tag, "_sb_empty"}, 32'(sbq[0].size() + sbq[1].size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin nxt[i] = '0; rem[i] = 0; end
    drive();
    repeat (2) @(posedge clk);
    #1;

    // Reset holds off handshakes even with both producers valid.
    rem[0] = 1; rem[1] = 1; drive();
    #3;
    chk("t1_rst_in_ready", 32'(in_ready), 0);
    chk("t1_rst_ff_push", 32'(ff_push), 0);
    chk("t1_rst_ff_pop", 32'(ff_pop), 0);
    chk("t1_rst_out_valid", 32'(out_valid), 0);
    cyc();
    rst = 1'b1;
    nxt[0] = 4'h1; nxt[1] = 4'h8; rem[0] = 100; rem[1] = 100; drive();

    // Both valid, consumer stalled: alternate grants until full.
    for (int k = 0; k < 6; k++) begin
      #3;
      chk("t2_in_ready", 32'(in_ready), 32'(EXP2[k]));
      if (k == 5) chk("t2_ff_full", 32'(ff_full), 1);
      cyc();
    end
    #3;
    chk("t2_out_valid", 32'(out_valid), 1);
    chk("t2_out_data", 32'(out_data), 32'h1);
    chk("t2_out_qid", 32'(out_qid), 0);
    rem[0] = 0; rem[1] = 0; out_ready = 1'b1; drive();
    qid_log.delete();
    drain("t2_drain");
    chk("t2_qid_count", 32'(qid_log.size()), 5);
    for (int k = 0; k < 5; k++)
      chk("t2_qid_seq", (k < qid_log.size()) ? 32'(qid_log[k]) : 32'hFFFF_FFFF, 32'(QID2[k]));

    // Minimum latency through an empty queue.
    nxt[1] = 4'h3; rem[1] = 1; drive();
    #3;
    chk("t4_in_ready", 32'(in_ready), 32'b10);
    cyc();
    #3;
    chk("t4_ff_pop", 32'(ff_pop), 1);
    chk("t4_ff_pop_sel", 32'(ff_pop_sel), 1);
    chk("t4_early_valid", 32'(out_valid), 0);
    cyc();
    #3;
    chk("t4_out_valid", 32'(out_valid), 1);
    chk("t4_out_data", 32'(out_data), 32'h3);
    chk("t4_out_qid", 32'(out_qid), 1);
    cyc();
    #3;
    chk("t4_after_valid", 32'(out_valid), 0);
    cyc();

    // Preload two words per queue, then stream them back to back.
    out_ready = 1'b0;
    nxt[0] = 4'h4; nxt[1] = 4'hC; rem[0] = 2; rem[1] = 2; drive();
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("t5_in_ready", 32'(in_ready), 32'(EXP5[k]));
      cyc();
    end
    #3;
    chk("t5_hold_valid", 32'(out_valid), 1);
    chk("t5_hold_qid", 32'(out_qid), 0);
    chk("t5_hold_data", 32'(out_data), 32'h4);
    out_ready = 1'b1;
    qid_log.delete();
    cyc();
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("t5_no_bubble", 32'(out_valid), 1);
      cyc();
    end
    #3;
    chk("t5_end_valid", 32'(out_valid), 0);
    chk("t5_qid_count", 32'(qid_log.size()), 4);
    for (int k = 0; k < 4; k++)
      chk("t5_qid_seq", (k < qid_log.size()) ? 32'(qid_log[k]) : 32'hFFFF_FFFF, 32'(QID5[k]));
    cyc();

    // Single producer against the quota with the output stalled.
    out_ready = 1'b0;
    nxt[0] = 4'hA; rem[0] = 9; drive();
    for (int k = 0; k < 5; k++) begin
      #3;
      chk("t3_in_ready", 32'(in_ready), 32'(EXP3[k]));
      if (k >= 2) begin
        chk("t3_out_valid", 32'(out_valid), 1);
        chk("t3_out_data", 32'(out_data), 32'hA);
      end
      cyc();
    end

    // Reset while the output register and counts are loaded.
    rst = 1'b0; rem[0] = 1; drive();
    #3;
    chk("t6_rst_in_ready", 32'(in_ready), 0);
    chk("t6_rst_ff_push", 32'(ff_push), 0);
    chk("t6_rst_ff_pop", 32'(ff_pop), 0);
    cyc();
    sbq[0].delete(); sbq[1].delete();
    rst = 1'b1; drive();
    #3;
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_out_data", 32'(out_data), 0);
    chk("t6_out_qid", 32'(out_qid), 0);
    chk("t6_cnt_err", 32'(cnt_err), 0);
    chk("t6_ff_pop", 32'(ff_pop), 0);
    chk("t6_in_ready", 32'(in_ready), 32'b01);
    out_ready = 1'b1;
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
